// File: rtl/ctrl_pipe_dec.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pipe_dec
// Purpose  : MIPS-I decode plus control pipeline. Decodes op/funct/rt in ID
//            into a 20-bit control bundle, carries it through STAGES
//            registered stages (EX, MEM, ..., WB) and sequences multi-cycle
//            DIV/DIVU with a busy FSM that holds the pipe and issues
//            start/annul strobes to the divider.
// Ports    : clk, rst         clock, synchronous active-high reset
//            op_i/funct_i/rt_i  ID instruction fields
//            id_valid_i       ID slot holds a real instruction
//            flush_e_i        kill the instruction entering/occupying EX
//            ex/mem/wb_ctrl_o control bundle in EX, stage2, stage STAGES
//            stall_id_o       freeze PC and IF/ID while the divider runs
//            div_start_o/div_sign_o/div_annul_o/div_done_o  divider handshake
//            ri_exc_o         reserved-instruction flag for the EX instruction
// Macro    : CTRL_TRAP_EN     enables the reserved-instruction flag
// Revision : 1.0  initial release
// ============================================================================
module ctrl_pipe_dec #(
  parameter int STAGES  = 3,
  parameter int DIV_LAT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  op_i,
  input  logic [5:0]  funct_i,
  input  logic [4:0]  rt_i,
  input  logic        id_valid_i,
  input  logic        flush_e_i,
  output logic [19:0] ex_ctrl_o,
  output logic [19:0] mem_ctrl_o,
  output logic [19:0] wb_ctrl_o,
  output logic        stall_id_o,
  output logic        div_start_o,
  output logic        div_sign_o,
  output logic        div_annul_o,
  output logic        div_done_o,
  output logic        ri_exc_o
);

`ifdef CTRL_TRAP_EN
  localparam bit c_trap_en = 1'b1;
`else
  localparam bit c_trap_en = 1'b0;
`endif

  localparam int                 c_cnt_w    = $clog2(DIV_LAT);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DIV_LAT - 1);

  typedef struct packed {
    logic       regwrite;
    logic [1:0] datatoreg;   // 00 ALU, 10 HI, 11 LO
    logic       memwrite;
    logic       alusrca;     // shamt as operand A
    logic [1:0] alusrcb;     // 01 sign-ext imm, 10 zero-ext imm
    logic       regdst;
    logic       jump;
    logic       branch;
    logic       hiwrite;
    logic       lowrite;
    logic [1:0] datatohi;    // 01 rs, 10 divider, 11 multiplier
    logic [1:0] datatolo;
    logic       sign;        // signed MULT/DIV
    logic       jal;
    logic       jr;
    logic       bal;
  } ctrl_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  ctrl_t dec, id_ctrl, ex_gated;
  logic  dec_listed;

  ctrl_t ex_q, mem_q;
  ctrl_t tail_q [3:STAGES];
  logic  ri_q;

  state_t             state_q, state_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic               ex_div, hold, start, annul, done;

  // ---------------------------------------------------------------- decode
  always_comb begin
    dec        = '0;
    dec_listed = 1'b1;
    case (op_i)
      6'b000000: begin
        case (funct_i)
          6'b100000, 6'b100001, 6'b100010, 6'b100011,
          6'b100100, 6'b100101, 6'b100110, 6'b100111,
          6'b101010, 6'b101011: begin
            dec.regwrite = 1'b1; dec.regdst = 1'b1;
          end
          6'b000000, 6'b000010, 6'b000011: begin
            dec.regwrite = 1'b1; dec.regdst = 1'b1; dec.alusrca = 1'b1;
          end
          6'b000100, 6'b000110, 6'b000111: begin
            dec.regwrite = 1'b1; dec.regdst = 1'b1;
          end
          6'b010000: begin
            dec.regwrite = 1'b1; dec.regdst = 1'b1; dec.datatoreg = 2'b10;
          end
          6'b010010: begin
            dec.regwrite = 1'b1; dec.regdst = 1'b1; dec.datatoreg = 2'b11;
          end
          6'b010001: begin dec.hiwrite = 1'b1; dec.datatohi = 2'b01; end
          6'b010011: begin dec.lowrite = 1'b1; dec.datatolo = 2'b01; end
          6'b011000, 6'b011001: begin
            dec.hiwrite  = 1'b1;  dec.lowrite  = 1'b1;
            dec.datatohi = 2'b11; dec.datatolo = 2'b11;
            dec.sign     = ~funct_i[0];
          end
          6'b011010, 6'b011011: begin
            dec.hiwrite  = 1'b1;  dec.lowrite  = 1'b1;
            dec.datatohi = 2'b10; dec.datatolo = 2'b10;
            dec.sign     = ~funct_i[0];
          end
          6'b001000: dec.jr = 1'b1;
          6'b001001: begin
            dec.regwrite = 1'b1; dec.regdst = 1'b1; dec.jr = 1'b1; dec.jal = 1'b1;
          end
          default: dec_listed = 1'b0;
        endcase
      end
      6'b000001: begin
        case (rt_i)
          5'b00000, 5'b00001: dec.branch = 1'b1;
          5'b10000, 5'b10001: begin
            dec.branch = 1'b1; dec.regwrite = 1'b1; dec.bal = 1'b1;
          end
          default: dec_listed = 1'b0;
        endcase
      end
      6'b000010: dec.jump = 1'b1;
      6'b000011: begin dec.jump = 1'b1; dec.regwrite = 1'b1; dec.jal = 1'b1; end
      6'b000100, 6'b000101, 6'b000110, 6'b000111: dec.branch = 1'b1;
      6'b001000, 6'b001001, 6'b001010, 6'b001011: begin
        dec.regwrite = 1'b1; dec.alusrcb = 2'b01;
      end
      6'b001100, 6'b001101, 6'b001110, 6'b001111: begin
        dec.regwrite = 1'b1; dec.alusrcb = 2'b10;
      end
      default: dec_listed = 1'b0;
    endcase
  end

  assign id_ctrl = id_valid_i ? dec : '0;

  // ------------------------------------------------------------ divider FSM
  assign ex_div = (ex_q.datatohi == 2'b10);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold    = 1'b0;
    start   = 1'b0;
    annul   = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ex_div && !flush_e_i) begin
          hold    = 1'b1;
          start   = 1'b1;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        hold  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (flush_e_i) begin
          annul   = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q == c_cnt_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (flush_e_i) annul = 1'b1;
        else           done  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A DIV only commits HI/LO in the cycle the divider result is valid.
  always_comb begin
    ex_gated = ex_q;
    if (ex_div && !done) begin
      ex_gated.hiwrite = 1'b0;
      ex_gated.lowrite = 1'b0;
    end
  end

  // ------------------------------------------------------------ stage regs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ex_q    <= '0;
      mem_q   <= '0;
      ri_q    <= 1'b0;
      for (int k = 3; k <= STAGES; k++) tail_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (flush_e_i) begin
        ex_q <= '0;
        ri_q <= 1'b0;
      end else if (!hold) begin
        ex_q <= id_ctrl;
        ri_q <= c_trap_en & id_valid_i & ~dec_listed;
      end
      // While EX is held, MEM sees a bubble; the stages behind it drain.
      mem_q     <= hold ? '0 : ex_gated;
      tail_q[3] <= mem_q;
      for (int k = 4; k <= STAGES; k++) tail_q[k] <= tail_q[k-1];
    end
  end

  assign ex_ctrl_o   = ex_gated;
  assign mem_ctrl_o  = mem_q;
  assign wb_ctrl_o   = tail_q[STAGES];
  assign stall_id_o  = hold;
  assign div_start_o = start;
  assign div_sign_o  = start & ex_q.sign;
  assign div_annul_o = annul;
  assign div_done_o  = done;
  assign ri_exc_o    = ri_q;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe_dec.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_pipe_dec
// Purpose  : Self-checking bench for ctrl_pipe_dec (STAGES=3, DIV_LAT=4).
//            Reference model tracks each instruction's age in EX instead of
//            an FSM; ID is held whenever the model predicts a stall.
// Revision : 1.0  initial release
// ============================================================================
module tb_ctrl_pipe_dec;
  localparam int STAGES  = 3;
  localparam int DIV_LAT = 4;
`ifdef CTRL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [5:0]  op = '0, funct = '0;
  logic [4:0]  rt = '0;
  logic        id_valid = 1'b0, flush_e = 1'b0;
  logic [19:0] ex_ctrl, mem_ctrl, wb_ctrl;
  logic        stall_id, div_start, div_sign, div_annul, div_done, ri_exc;

  ctrl_pipe_dec #(.STAGES(STAGES), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst(rst), .op_i(op), .funct_i(funct), .rt_i(rt),
    .id_valid_i(id_valid), .flush_e_i(flush_e),
    .ex_ctrl_o(ex_ctrl), .mem_ctrl_o(mem_ctrl), .wb_ctrl_o(wb_ctrl),
    .stall_id_o(stall_id), .div_start_o(div_start), .div_sign_o(div_sign),
    .div_annul_o(div_annul), .div_done_o(div_done), .ri_exc_o(ri_exc)
  );

  int n_pass = 0, n_total = 0, n_fail = 0, cyc_n = 0;

  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s @cycle %0d: observed %h expected %h", tag, cyc_n, obs, exp);
    end
  endtask

  // Decode reference: returns {legal, bundle}. Bundle bit map:
  // 19 regwrite, 18:17 datatoreg, 16 memwrite, 15 alusrca, 14:13 alusrcb,
  // 12 regdst, 11 jump, 10 branch, 9 hiwrite, 8 lowrite, 7:6 datatohi,
  // 5:4 datatolo, 3 sign, 2 jal, 1 jr, 0 bal
  function automatic logic [20:0] ref_dec(input logic [5:0] o, input logic [5:0] f,
                                          input logic [4:0] r);
    logic [19:0] b;
    logic        ok;
    b = '0; ok = 1'b1;
    if (o == 0) begin
      if (f inside {32, 33, 34, 35, 36, 37, 38, 39, 42, 43, 4, 6, 7}) begin
        b[19] = 1; b[12] = 1;
      end else if (f inside {0, 2, 3}) begin
        b[19] = 1; b[12] = 1; b[15] = 1;
      end else if (f == 16) begin b[19] = 1; b[12] = 1; b[18:17] = 2'b10; end
      else if (f == 18) begin b[19] = 1; b[12] = 1; b[18:17] = 2'b11; end
      else if (f == 17) begin b[9] = 1; b[7:6] = 2'b01; end
      else if (f == 19) begin b[8] = 1; b[5:4] = 2'b01; end
      else if (f == 24 || f == 25) begin
        b[9] = 1; b[8] = 1; b[7:6] = 2'b11; b[5:4] = 2'b11; b[3] = (f == 24);
      end else if (f == 26 || f == 27) begin
        b[9] = 1; b[8] = 1; b[7:6] = 2'b10; b[5:4] = 2'b10; b[3] = (f == 26);
      end else if (f == 8) b[1] = 1;
      else if (f == 9) begin b[19] = 1; b[12] = 1; b[1] = 1; b[2] = 1; end
      else ok = 0;
    end else if (o == 1) begin
      if (r == 0 || r == 1) b[10] = 1;
      else if (r == 16 || r == 17) begin b[10] = 1; b[19] = 1; b[0] = 1; end
      else ok = 0;
    end else if (o == 2) b[11] = 1;
    else if (o == 3) begin b[11] = 1; b[19] = 1; b[2] = 1; end
    else if (o >= 4 && o <= 7) b[10] = 1;
    else if (o >= 8 && o <= 11) begin b[19] = 1; b[14:13] = 2'b01; end
    else if (o >= 12 && o <= 15) begin b[19] = 1; b[14:13] = 2'b10; end
    else ok = 0;
    return {ok, b};
  endfunction

  typedef struct { logic [5:0] o; logic [5:0] f; logic [4:0] r; logic v; } ins_t;
  ins_t q[$];

  // ID slot (IF/ID register emulation) and model state
  logic [5:0]  id_op = '0, id_f = '0;
  logic [4:0]  id_rt = '0;
  logic        id_v = 1'b0;
  logic [19:0] m_ex = '0;
  logic        m_exdiv = 1'b0, m_ri = 1'b0;
  int          m_age = 0;
  logic [19:0] m_stg [2:STAGES];

  task automatic push(input logic [5:0] o, input logic [5:0] f, input logic [4:0] r);
    ins_t i;
    i.o = o; i.f = f; i.r = r; i.v = 1'b1;
    q.push_back(i);
  endtask

  task automatic step(input logic fl, input logic rs, input logic do_chk);
    logic [19:0] e_ex;
    logic [20:0] d;
    logic e_stall, e_start, e_sign, e_annul, e_done, busy, last;
    ins_t ni;
    @(negedge clk);
    rst = rs; flush_e = fl;
    op = id_op; funct = id_f; rt = id_rt; id_valid = id_v;
    #1;
    busy    = m_exdiv && m_age >= 2 && m_age <= DIV_LAT + 1;
    last    = m_exdiv && m_age == DIV_LAT + 2;
    e_start = m_exdiv && m_age == 1 && !fl;
    e_stall = e_start || busy;
    e_annul = fl && (busy || last);
    e_done  = last && !fl;
    e_sign  = e_start && m_ex[3];
    e_ex    = m_ex;
    if (m_exdiv && !e_done) e_ex[9:8] = 2'b00;
    if (do_chk) begin
      chk("ex_ctrl", ex_ctrl, e_ex);
      chk("mem_ctrl", mem_ctrl, m_stg[2]);
      chk("wb_ctrl", wb_ctrl, m_stg[STAGES]);
      chk("stall_id", {19'd0, stall_id}, {19'd0, e_stall});
      chk("div_start", {19'd0, div_start}, {19'd0, e_start});
      chk("div_sign", {19'd0, div_sign}, {19'd0, e_sign});
      chk("div_annul", {19'd0, div_annul}, {19'd0, e_annul});
      chk("div_done", {19'd0, div_done}, {19'd0, e_done});
      chk("ri_exc", {19'd0, ri_exc}, {19'd0, m_ri});
    end
    if (rs) begin
      m_ex = '0; m_exdiv = 0; m_ri = 0; m_age = 0;
      for (int k = 2; k <= STAGES; k++) m_stg[k] = '0;
    end else begin
      for (int k = STAGES; k >= 3; k--) m_stg[k] = m_stg[k-1];
      m_stg[2] = e_stall ? 20'd0 : e_ex;
      if (fl) begin
        m_ex = '0; m_exdiv = 0; m_ri = 0; m_age = 0;
      end else if (e_stall) begin
        m_age++;
      end else begin
        d       = ref_dec(id_op, id_f, id_rt);
        m_ex    = id_v ? d[19:0] : 20'd0;
        m_exdiv = id_v && id_op == 0 && (id_f == 26 || id_f == 27);
        m_ri    = TRAP && id_v && !d[20];
        m_age   = 1;
      end
      if (!e_stall) begin
        if (q.size() > 0) begin
          ni = q.pop_front();
          id_op = ni.o; id_f = ni.f; id_rt = ni.r; id_v = ni.v;
        end else id_v = 1'b0;
      end
    end
    cyc_n++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [5:0] r_list [17];
  logic [5:0] o_list [14];

  initial begin
    int s_idx, n_stall, d_idx, hl_bad, found, nd, ns, mst;
    logic [19:0] hl_done;
    int st_cyc[$];
    ins_t ri;
    r_list = '{32, 33, 34, 35, 36, 37, 38, 39, 42, 43, 0, 2, 3, 16, 17, 18, 19};
    o_list = '{2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
    for (int k = 2; k <= STAGES; k++) m_stg[k] = '0;

    // Reset: first cycle unchecked (registers not yet initialised)
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);

    // 1. ADDI through to WB
    push(6'd8, 6'd0, 5'd0);
    run(3);
    chk("t1_addi_ex", ex_ctrl, 20'h82000);
    run(2);
    chk("t1_addi_wb", wb_ctrl, 20'h82000);
    run(2);

    // 2. DIV timing
    push(6'd0, 6'd26, 5'd0);
    s_idx = -1; n_stall = 0; d_idx = -1; hl_bad = 0; hl_done = '0;
    for (int i = 0; i < 14; i++) begin
      step(1'b0, 1'b0, 1'b1);
      if (div_start === 1'b1 && s_idx < 0) begin
        s_idx = i;
        chk("t2_div_sign", {19'd0, div_sign}, 20'd1);
      end
      if (stall_id === 1'b1) n_stall++;
      if (div_done === 1'b1) begin d_idx = i; hl_done = {18'd0, ex_ctrl[9:8]}; end
      else if (ex_ctrl[9:8] !== 2'b00) hl_bad++;
    end
    chk("t2_stall_cycles", n_stall, 20'd5);
    chk("t2_done_offset", d_idx - s_idx, 20'd5);
    chk("t2_hilo_at_done", hl_done, 20'd3);
    chk("t2_hilo_early", hl_bad, 20'd0);

    // 3. DIVU annulled in its second BUSY cycle
    push(6'd0, 6'd27, 5'd0);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1'b0, 1'b0, 1'b1);
      if (div_start === 1'b1) found = 1;
    end
    chk("t3_start_seen", found, 20'd1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    chk("t3_annul", {19'd0, div_annul}, 20'd1);
    step(1'b0, 1'b0, 1'b1);
    chk("t3_ex_zero", ex_ctrl, 20'd0);
    chk("t3_stall_drop", {19'd0, stall_id}, 20'd0);
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b1);
      if (div_done === 1'b1) nd++;
    end
    chk("t3_no_done", nd, 20'd0);

    // 4. REGIMM: BGEZAL then unlisted rt
    push(6'd1, 6'd0, 5'd17);
    push(6'd1, 6'd0, 5'd7);
    run(3);
    chk("t4_bgezal", ex_ctrl, 20'h80401);
    run(1);
    chk("t4_regimm_bad", ex_ctrl, 20'd0);
    run(2);

    // 5. Two adjacent DIVs then MULT
    push(6'd0, 6'd26, 5'd0);
    push(6'd0, 6'd26, 5'd0);
    push(6'd0, 6'd24, 5'd0);
    mst = 0; ns = 0;
    for (int i = 0; i < 24; i++) begin
      step(1'b0, 1'b0, 1'b1);
      if (div_start === 1'b1) st_cyc.push_back(cyc_n);
      if (ex_ctrl[7:6] === 2'b11) begin
        ns++;
        if (stall_id !== 1'b0 || ex_ctrl[9:8] !== 2'b11) mst++;
      end
    end
    chk("t5_start_count", st_cyc.size(), 20'd2);
    if (st_cyc.size() == 2) chk("t5_start_gap", st_cyc[1] - st_cyc[0], 20'd6);
    chk("t5_mult_seen", ns, 20'd1);
    chk("t5_mult_nostall", mst, 20'd0);

    // 6. Reserved opcode
    push(6'd63, 6'd0, 5'd0);
    run(3);
    chk("t6_ri_bundle", ex_ctrl, 20'd0);
    chk("t6_ri_exc", {19'd0, ri_exc}, {19'd0, TRAP});
    run(2);

    // rst while BUSY: no annul, pipe zeroed
    push(6'd0, 6'd27, 5'd0);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1'b0, 1'b0, 1'b1);
      if (div_start === 1'b1) found = 1;
    end
    chk("t7_start_seen", found, 20'd1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    chk("t7_no_annul", {19'd0, div_annul}, 20'd0);
    step(1'b0, 1'b0, 1'b1);
    chk("t7_ex_zero", ex_ctrl, 20'd0);
    chk("t7_stall_zero", {19'd0, stall_id}, 20'd0);
    run(10);

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      if (q.size() < 2) begin
        ri.v = 1'b1; ri.r = 5'($urandom_range(0, 31)); ri.f = 6'($urandom_range(0, 63));
        case ($urandom_range(0, 9))
          0, 1, 2: begin ri.o = 6'd0; ri.f = 6'(26 + $urandom_range(0, 1)); end
          3:       begin ri.o = 6'd0; ri.f = 6'(24 + $urandom_range(0, 1)); end
          4:       begin ri.o = 6'd0; ri.f = r_list[$urandom_range(0, 16)]; end
          5:       ri.o = o_list[$urandom_range(0, 13)];
          6:       begin ri.o = 6'd1; ri.r = 5'({$urandom_range(0, 1), 3'b000,
                                                $urandom_range(0, 1)}); end
          7:       ri.o = 6'($urandom_range(0, 63));
          8:       begin ri.o = 6'd0; ri.f = 6'd26; ri.v = 1'b0; end
          default: ri.o = 6'd0;
        endcase
        q.push_back(ri);
      end
      step($urandom_range(0, 9) == 0, $urandom_range(0, 199) == 0, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
